// File: rtl/rvx_dm_pkg.sv
// Shared state encoding, bus geometry and legal byte-mask constants for the data-memory arbiter.
package rvx_dm_pkg;

  localparam int BUS_W   = 32;
  localparam int DM_SIZE = 8192;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_state_t;

  // Bytes touched by a legal mask; 0 marks an illegal mask.
  function automatic logic [2:0] mask_bytes(input logic [3:0] mask);
    case (mask)
      MASK_B:  return 3'd1;
      MASK_H:  return 3'd2;
      MASK_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Two requester ports (CPU m0, AES/DMA m1) plus the data-memory port; slave = arbiter side.
interface dm_arbiter_if #(
  parameter int BUS_W = rvx_dm_pkg::BUS_W
);
  logic             m0_req;
  logic             m0_we;
  logic [BUS_W-1:0] m0_addr;
  logic [BUS_W-1:0] m0_wdata;
  logic [3:0]       m0_mask;
  logic             m0_ack;
  logic             m0_err;
  logic [BUS_W-1:0] m0_rdata;

  logic             m1_req;
  logic             m1_we;
  logic [BUS_W-1:0] m1_addr;
  logic [BUS_W-1:0] m1_wdata;
  logic [3:0]       m1_mask;
  logic             m1_lock;
  logic             m1_ack;
  logic             m1_err;
  logic [BUS_W-1:0] m1_rdata;

  logic [BUS_W-1:0] dm_addr;
  logic [BUS_W-1:0] dm_wdata;
  logic             dm_we;
  logic             dm_re;
  logic [3:0]       dm_mask;
  logic [BUS_W-1:0] dm_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_lock,
    output m1_ack, m1_err, m1_rdata,
    output dm_addr, dm_wdata, dm_we, dm_re, dm_mask,
    input  dm_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_lock,
    input  m1_ack, m1_err, m1_rdata,
    input  dm_addr, dm_wdata, dm_we, dm_re, dm_mask,
    output dm_rdata
  );

endinterface

// File: rtl/dm_rr_pick.sv
// Winner selection between m0 and m1: round-robin with an m1 burst lock capped at MAX_BURST.
// Combinational pick; pointer and burst counter advance only on grant_en.
module dm_rr_pick #(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  input  logic m1_lock,
  input  logic grant_en,
  output logic pick_m1
);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic          last_m1;
  logic [CW-1:0] burst_cnt;
  logic          burst_full;
  logic          hold_m1;

  assign burst_full = (burst_cnt == CW'(MAX_BURST));
  assign hold_m1    = m1_lock && last_m1 && !burst_full;

  always_comb begin
    pick_m1 = 1'b0;
    if (m1_req && !m0_req) pick_m1 = 1'b1;
    else if (m1_req && m0_req) pick_m1 = hold_m1 || !last_m1;
  end

  // Reset points at m1 so the first contested grant goes to m0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_m1   <= 1'b1;
      burst_cnt <= '0;
    end else if (grant_en) begin
      last_m1 <= pick_m1;
      if (pick_m1 && m1_lock) begin
        if (!burst_full) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end else if (!m1_lock) begin
      burst_cnt <= '0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter: IDLE samples/latches, ACCESS drives memory, RESP acks; req->ack 2 cycles.
// Requesters hold req+command until their ack; at most one access every 3 cycles.
module dm_arbiter #(
  parameter int BUS_W     = rvx_dm_pkg::BUS_W,
  parameter int DM_SIZE   = rvx_dm_pkg::DM_SIZE,
  parameter int MAX_BURST = 16
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);
  import rvx_dm_pkg::*;

  dm_state_t state_q, state_d;

  logic             grant_en;
  logic             pick_m1;
  logic             cmd_m1;
  logic             cmd_we;
  logic [BUS_W-1:0] cmd_addr;
  logic [BUS_W-1:0] cmd_wdata;
  logic [3:0]       cmd_mask;

  logic [2:0]       nbytes;
  logic             aligned;
  logic [BUS_W:0]   end_addr;
  logic             cmd_ok;

  logic [BUS_W-1:0] dm_addr_d, dm_wdata_d;
  logic [3:0]       dm_mask_d;
  logic             dm_we_d, dm_re_d;
  logic [BUS_W-1:0] resp_dat;

  logic             ack0_q, ack1_q, err0_q, err1_q;
  logic [BUS_W-1:0] rdata0_q, rdata1_q;

  assign grant_en = (state_q == IDLE) && (bus.m0_req || bus.m1_req);

  dm_rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (bus.m0_req),
    .m1_req   (bus.m1_req),
    .m1_lock  (bus.m1_lock),
    .grant_en (grant_en),
    .pick_m1  (pick_m1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    dm_addr_d  = '0;
    dm_wdata_d = '0;
    dm_mask_d  = '0;
    dm_we_d    = 1'b0;
    dm_re_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.m0_req || bus.m1_req) state_d = ACCESS;
      ACCESS: begin
        state_d    = RESP;
        dm_addr_d  = cmd_addr;
        dm_wdata_d = cmd_wdata;
        dm_mask_d  = cmd_mask;
        dm_we_d    = cmd_ok && cmd_we;
        dm_re_d    = cmd_ok && !cmd_we;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_m1    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_mask  <= '0;
    end else if (grant_en) begin
      cmd_m1    <= pick_m1;
      cmd_we    <= pick_m1 ? bus.m1_we    : bus.m0_we;
      cmd_addr  <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
      cmd_wdata <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
      cmd_mask  <= pick_m1 ? bus.m1_mask  : bus.m0_mask;
    end
  end

  // Legal: known mask, naturally aligned, and the last byte inside the memory.
  always_comb begin
    nbytes = mask_bytes(cmd_mask);
    case (nbytes)
      3'd1:    aligned = 1'b1;
      3'd2:    aligned = ~cmd_addr[0];
      3'd4:    aligned = (cmd_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    end_addr = {1'b0, cmd_addr} + {{(BUS_W-2){1'b0}}, nbytes};
    cmd_ok   = aligned && (end_addr <= (BUS_W+1)'(DM_SIZE));
  end

  assign resp_dat = (cmd_ok && !cmd_we) ? bus.dm_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      if (state_q == ACCESS) begin
        if (cmd_m1) begin
          ack1_q   <= 1'b1;
          err1_q   <= ~cmd_ok;
          rdata1_q <= resp_dat;
        end else begin
          ack0_q   <= 1'b1;
          err0_q   <= ~cmd_ok;
          rdata0_q <= resp_dat;
        end
      end
    end
  end

  assign bus.dm_addr  = dm_addr_d;
  assign bus.dm_wdata = dm_wdata_d;
  assign bus.dm_mask  = dm_mask_d;
  assign bus.dm_we    = dm_we_d;
  assign bus.dm_re    = dm_re_d;
  assign bus.m0_ack   = ack0_q;
  assign bus.m0_err   = err0_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m1_err   = err1_q;
  assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_dm_arbiter;
  localparam int DM   = 8192;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_arbiter_if #(.BUS_W(32)) bus ();

  dm_arbiter #(.BUS_W(32), .DM_SIZE(DM), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory: byte-addressed, combinational read of the four bytes starting at dm_addr.
  bit   [7:0]  mem     [DM];
  bit   [7:0]  ref_mem [DM];
  logic [31:0] rd;

  always @(posedge clk)
    if (bus.dm_we)
      for (int i = 0; i < 4; i++)
        if (bus.dm_mask[i] && ((bus.dm_addr + 32'(i)) < 32'(DM)))
          mem[13'(bus.dm_addr + 32'(i))] <= bus.dm_wdata[8*i +: 8];

  always_comb begin
    rd = '0;
    for (int i = 0; i < 4; i++)
      if ((bus.dm_addr + 32'(i)) < 32'(DM)) rd[8*i +: 8] = mem[13'(bus.dm_addr + 32'(i))];
  end
  assign bus.dm_rdata = rd;

  // Requester commands
  bit          q   [2];
  bit          cwe [2];
  logic [31:0] cad [2];
  logic [31:0] cwd [2];
  logic [3:0]  cmk [2];
  bit          lk;

  // Reference model state
  bit          m_last;
  int          m_burst;
  logic [31:0] exp_rd [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.m0_req   = q[0];   bus.m0_we    = cwe[0]; bus.m0_addr = cad[0];
    bus.m0_wdata = cwd[0]; bus.m0_mask  = cmk[0];
    bus.m1_req   = q[1];   bus.m1_we    = cwe[1]; bus.m1_addr = cad[1];
    bus.m1_wdata = cwd[1]; bus.m1_mask  = cmk[1]; bus.m1_lock = lk;
  endtask

  task automatic set_cmd(input int m, input bit we, input logic [31:0] a,
                         input logic [3:0] mk, input logic [31:0] d);
    q[m] = 1'b1; cwe[m] = we; cad[m] = a; cmk[m] = mk; cwd[m] = d;
  endtask

  task automatic rand_cmd(input int m);
    logic [31:0] a;
    logic [3:0]  mk;
    int          sel;
    sel = $urandom_range(0, 9);
    mk  = (sel < 3) ? 4'h1 : (sel < 6) ? 4'h3 : (sel < 9) ? 4'hF : 4'($urandom_range(0, 15));
    a   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(DM - 8, DM + 3)) : 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (mk == 4'h3) a[0] = 1'b0;
      if (mk == 4'hF) a[1:0] = 2'b00;
    end
    set_cmd(m, 1'($urandom_range(0, 1)), a, mk, $urandom);
  endtask

  function automatic bit is_legal(input logic [3:0] mk, input logic [31:0] a);
    longint n;
    case (mk)
      4'h1:    n = 1;
      4'h3:    n = a[0] ? 0 : 2;
      4'hF:    n = (a[1:0] != 2'b00) ? 0 : 4;
      default: n = 0;
    endcase
    return (n != 0) && ((longint'(a) + n) <= DM);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if ((longint'(a) + i) < DM) w[8*i +: 8] = ref_mem[13'(a + 32'(i))];
    return w;
  endfunction

  // Lone requester wins; under contention an unfinished m1 lock burst keeps m1, else the one that waited.
  function automatic bit model_pick(input bit r0, input bit r1, input bit lock);
    if (!r1) return 1'b0;
    if (!r0) return 1'b1;
    if (lock && m_last && (m_burst < MAXB)) return 1'b1;
    return !m_last;
  endfunction

  task automatic do_round(input bit extra_idle, output bit win);
    bit legal;
    win   = model_pick(q[0], q[1], lk);
    legal = is_legal(cmk[win], cad[win]);
    if (extra_idle) begin
      @(negedge clk);
      chk1("idle_we", bus.dm_we, 1'b0);
      chk1("idle_re", bus.dm_re, 1'b0);
      chk1("idle_ack0", bus.m0_ack, 1'b0);
      chk1("idle_ack1", bus.m1_ack, 1'b0);
    end
    @(negedge clk);
    chk1("acc_we", bus.dm_we, legal && cwe[win]);
    chk1("acc_re", bus.dm_re, legal && !cwe[win]);
    chk32("acc_addr", bus.dm_addr, cad[win]);
    chk32("acc_mask", 32'(bus.dm_mask), 32'(cmk[win]));
    chk32("acc_wdata", bus.dm_wdata, cwd[win]);
    chk1("acc_ack0", bus.m0_ack, 1'b0);
    chk1("acc_ack1", bus.m1_ack, 1'b0);
    exp_rd[win] = (legal && !cwe[win]) ? ref_word(cad[win]) : 32'h0;
    if (legal && cwe[win])
      for (int i = 0; i < 4; i++)
        if (cmk[win][i] && ((longint'(cad[win]) + i) < DM))
          ref_mem[13'(cad[win] + 32'(i))] = cwd[win][8*i +: 8];
    @(negedge clk);
    chk1("resp_ack0", bus.m0_ack, win == 1'b0);
    chk1("resp_ack1", bus.m1_ack, win == 1'b1);
    chk1("resp_err0", bus.m0_err, (win == 1'b0) && !legal);
    chk1("resp_err1", bus.m1_err, (win == 1'b1) && !legal);
    chk32("resp_rdata0", bus.m0_rdata, exp_rd[0]);
    chk32("resp_rdata1", bus.m1_rdata, exp_rd[1]);
    chk1("resp_we", bus.dm_we, 1'b0);
    m_last = win;
    if (win && lk) m_burst = (m_burst < MAXB) ? m_burst + 1 : m_burst;
    else           m_burst = 0;
  endtask

  initial begin
    bit w, prev;
    int nbad;
    rst = 1'b1;
    lk  = 1'b0;
    for (int m = 0; m < 2; m++) begin
      q[m] = 1'b0; cwe[m] = 1'b0; cad[m] = '0; cwd[m] = '0; cmk[m] = '0;
    end
    drive();
    repeat (2) @(negedge clk);
    chk1("rst_ack0", bus.m0_ack, 1'b0);
    chk1("rst_ack1", bus.m1_ack, 1'b0);
    chk1("rst_err0", bus.m0_err, 1'b0);
    chk1("rst_err1", bus.m1_err, 1'b0);
    chk1("rst_we", bus.dm_we, 1'b0);
    chk1("rst_re", bus.dm_re, 1'b0);
    chk32("rst_addr", bus.dm_addr, 32'h0);
    chk32("rst_rdata0", bus.m0_rdata, 32'h0);
    chk32("rst_rdata1", bus.m1_rdata, 32'h0);
    m_last = 1'b1; m_burst = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;

    // Word write then read back at 0x10
    set_cmd(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    drive(); do_round(1'b0, w);
    set_cmd(0, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(); do_round(1'b1, w);
    chk1("r024_win", w, 1'b0);
    chk32("r024_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk1("r024_err", bus.m0_err, 1'b0);

    // Both masters stream writes without lock: grants alternate
    for (int m = 0; m < 2; m++) set_cmd(m, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'hF, $urandom);
    prev = w;
    for (int k = 0; k < 8; k++) begin
      drive(); do_round(1'b1, w);
      chk1("r025_alt", w, !prev);
      prev = w;
      set_cmd(w, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'hF, $urandom);
    end

    // Misaligned halfword and word that runs off the end of memory
    set_cmd(1, 1'b1, 32'h101, 4'h3, 32'hCAFE1234);
    set_cmd(0, 1'b0, 32'h1FFE, 4'hF, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(); do_round(1'b1, w);
      chk1("r027_err", w ? bus.m1_err : bus.m0_err, 1'b1);
      chk32("r027_rdata", w ? bus.m1_rdata : bus.m0_rdata, 32'h0);
      q[w] = 1'b0;
    end

    // Reset in the middle of an m0 write access
    set_cmd(0, 1'b1, 32'h20, 4'hF, 32'h12345678);
    drive();
    @(negedge clk);
    @(negedge clk);
    chk1("r028_we_before", bus.dm_we, 1'b1);
    rst = 1'b1;
    #1;
    chk1("r028_we_drop", bus.dm_we, 1'b0);
    chk1("r028_re_drop", bus.dm_re, 1'b0);
    q[0] = 1'b0; drive();
    @(negedge clk);
    chk1("r028_noack0", bus.m0_ack, 1'b0);
    chk1("r028_noack1", bus.m1_ack, 1'b0);
    chk32("r028_rdata0", bus.m0_rdata, 32'h0);
    for (int i = 0; i < 4; i++) chk32("r028_mem", 32'(mem[32 + i]), 32'(ref_mem[32 + i]));
    m_last = 1'b1; m_burst = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;
    set_cmd(0, 1'b0, 32'h10, 4'hF, 32'h0);
    set_cmd(1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(); do_round(1'b0, w);
    chk1("r028_first_tie", w, 1'b0);

    // Locked m1 burst against a continuously requesting m0
    lk = 1'b1;
    for (int m = 0; m < 2; m++) set_cmd(m, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'hF, $urandom);
    for (int k = 0; k < 34; k++) begin
      drive(); do_round(1'b1, w);
      chk1("r026_grant", w, !((k == 16) || (k == 33)));
      set_cmd(w, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'hF, $urandom);
    end

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 4) == 0) lk = !lk;
      if ($urandom_range(0, 4) != 0) rand_cmd(w);
      else q[w] = 1'b0;
      if (!q[!w] && ($urandom_range(0, 1) == 1)) rand_cmd(!w);
      if (!q[0] && !q[1]) rand_cmd(0);
      drive(); do_round(1'b1, w);
    end

    nbad = 0;
    for (int i = 0; i < DM; i++) if (mem[i] != ref_mem[i]) nbad++;
    chk32("mem_final", 32'(nbad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
